// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Block-fill engine between the cache arrays and a pipelined, multi-cycle main
// memory. On a miss it latches the block base, issues one word read per cycle,
// writes each returned word into the cache data array, and writes the tag
// together with the last data word. While idle it forwards single-word
// write-through stores straight to memory in the same cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   miss_detected/_addr miss request (level) and the byte address that missed
//   cpu_wr_req/_addr/_data, cpu_wr_ack
//                       write-through store request and same-cycle acknowledge
//   fsm_busy            high while a fill is in progress
//   mem_enable, mem_wr, mem_addr, mem_data_in, mem_data_out, mem_data_valid
//                       memory command, write data, and read return
//   write_data_array, cache_word_addr, cache_data
//                       cache data-array write port
//   write_tag_array, tag_addr
//                       cache tag-array write port
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  cpu_wr_req,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [15:0]           cpu_wr_data,
  output logic                  cpu_wr_ack,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] cache_word_addr,
  output logic [15:0]           cache_data,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] tag_addr
);

  // Byte-offset bits within a block (16-bit words, so one extra bit).
  localparam int OFS = $clog2(BLOCK_WORDS) + 1;

  localparam logic [OFS-1:0] LP_WORDS = OFS'(BLOCK_WORDS);
  localparam logic [OFS-1:0] LP_LAST  = OFS'(BLOCK_WORDS - 1);
  localparam logic [OFS-1:0] LP_ONE   = {{(OFS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic [OFS-1:0]        r_issue_cnt;
  logic [OFS-1:0]        w_issue_cnt_nxt;
  logic [OFS-1:0]        r_ret_cnt;
  logic [OFS-1:0]        w_ret_cnt_nxt;

  logic                  w_cpu_wr_ack;
  logic                  w_mem_enable;
  logic                  w_mem_wr;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [15:0]           w_mem_data_in;
  logic                  w_write_data_array;
  logic [ADDR_WIDTH-1:0] w_cache_word_addr;
  logic [15:0]           w_cache_data;
  logic                  w_write_tag_array;

  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [ADDR_WIDTH-1:0] w_ret_addr;
  logic                  w_unused_miss_ofs;

  // Word addresses within the block. Counters are only used as offsets while
  // below BLOCK_WORDS, so their top bit never contributes; the base has zero
  // low bits, so the addition cannot carry into the tag.
  assign w_issue_addr = r_base + {{(ADDR_WIDTH-OFS){1'b0}}, r_issue_cnt[OFS-2:0], 1'b0};
  assign w_ret_addr   = r_base + {{(ADDR_WIDTH-OFS){1'b0}}, r_ret_cnt[OFS-2:0], 1'b0};

  // The offset bits of the miss address are discarded when the base is latched.
  assign w_unused_miss_ofs = ^miss_address[OFS-1:0];

  // State, block base and issue/return counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= {ADDR_WIDTH{1'b0}};
      r_issue_cnt <= {OFS{1'b0}};
      r_ret_cnt   <= {OFS{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_ret_cnt   <= w_ret_cnt_nxt;
    end
  end

  // Next-state logic and the combinational memory/cache strobes.
  always_comb begin
    w_state_nxt        = r_state;
    w_base_nxt         = r_base;
    w_issue_cnt_nxt    = r_issue_cnt;
    w_ret_cnt_nxt      = r_ret_cnt;
    w_cpu_wr_ack       = 1'b0;
    w_mem_enable       = 1'b0;
    w_mem_wr           = 1'b0;
    w_mem_addr         = {ADDR_WIDTH{1'b0}};
    w_mem_data_in      = 16'h0000;
    w_write_data_array = 1'b0;
    w_cache_word_addr  = {ADDR_WIDTH{1'b0}};
    w_cache_data       = 16'h0000;
    w_write_tag_array  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A miss wins over a store in the same cycle; the store is not acked
        // and simply stays pending at the CPU. Stray read returns are dropped.
        if (miss_detected) begin
          w_state_nxt     = S_FILL;
          w_base_nxt      = {miss_address[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
          w_issue_cnt_nxt = {OFS{1'b0}};
          w_ret_cnt_nxt   = {OFS{1'b0}};
        end else if (cpu_wr_req) begin
          w_cpu_wr_ack  = 1'b1;
          w_mem_enable  = 1'b1;
          w_mem_wr      = 1'b1;
          w_mem_addr    = cpu_wr_addr;
          w_mem_data_in = cpu_wr_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FILL: begin
        // Issue side: one read per cycle until the whole block is requested.
        if (r_issue_cnt < LP_WORDS) begin
          w_mem_enable    = 1'b1;
          w_mem_addr      = w_issue_addr;
          w_issue_cnt_nxt = r_issue_cnt + LP_ONE;
        end else begin
          w_mem_enable = 1'b0;
        end

        // Return side: every valid word goes straight into the data array;
        // the tag is written alongside the final word.
        if (mem_data_valid) begin
          w_write_data_array = 1'b1;
          w_cache_word_addr  = w_ret_addr;
          w_cache_data       = mem_data_out;
          w_ret_cnt_nxt      = r_ret_cnt + LP_ONE;
          if (r_ret_cnt == LP_LAST) begin
            w_write_tag_array = 1'b1;
            w_state_nxt       = S_IDLE;
          end else begin
            w_write_tag_array = 1'b0;
          end
        end else begin
          w_write_data_array = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every output is forced low while reset is held, including the
  // combinational store path that would otherwise follow cpu_wr_req.
  assign cpu_wr_ack       = rst ? 1'b0 : w_cpu_wr_ack;
  assign fsm_busy         = rst ? 1'b0 : (r_state == S_FILL);
  assign mem_enable       = rst ? 1'b0 : w_mem_enable;
  assign mem_wr           = rst ? 1'b0 : w_mem_wr;
  assign mem_addr         = rst ? {ADDR_WIDTH{1'b0}} : w_mem_addr;
  assign mem_data_in      = rst ? 16'h0000 : w_mem_data_in;
  assign write_data_array = rst ? 1'b0 : w_write_data_array;
  assign cache_word_addr  = rst ? {ADDR_WIDTH{1'b0}} : w_cache_word_addr;
  assign cache_data       = rst ? 16'h0000 : w_cache_data;
  assign write_tag_array  = rst ? 1'b0 : w_write_tag_array;
  assign tag_addr         = rst ? {ADDR_WIDTH{1'b0}} : r_base;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Self-checking bench for cache_fill_fsm (ADDR_WIDTH=16, BLOCK_WORDS=8).
// A memory model returns read data four cycles after the enable cycle; unwritten
// words read back as their own byte address. Expected reads, cache writes, tag
// writes and forwarded stores are queued when stimulus is driven and compared
// when the DUT produces them. IDLE behaviour is covered by a vector table,
// fills and reset-mid-fill by hand-written cycle sequences.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        cpu_wr_req;
  logic [15:0] cpu_wr_addr;
  logic [15:0] cpu_wr_data;
  logic        cpu_wr_ack;
  logic        fsm_busy;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        write_data_array;
  logic [15:0] cache_word_addr;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic [15:0] tag_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .cpu_wr_req       (cpu_wr_req),
    .cpu_wr_addr      (cpu_wr_addr),
    .cpu_wr_data      (cpu_wr_data),
    .cpu_wr_ack       (cpu_wr_ack),
    .fsm_busy         (fsm_busy),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_data_valid   (mem_data_valid),
    .write_data_array (write_data_array),
    .cache_word_addr  (cache_word_addr),
    .cache_data       (cache_data),
    .write_tag_array  (write_tag_array),
    .tag_addr         (tag_addr)
  );

  // ---------------- memory model: 4-cycle read latency ----------------
  logic [15:0]    mem_arr [0:32767];
  logic [32767:0] mem_set = '0;
  logic [3:0]     pipe_v  = 4'b0000;
  logic [15:0]    pipe_d [0:3];
  logic           stray_v = 1'b0;
  logic [15:0]    stray_d = 16'h0000;

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem_arr[mem_addr[15:1]] <= mem_data_in;
      mem_set[mem_addr[15:1]] <= 1'b1;
    end
    pipe_v    <= {pipe_v[2:0], mem_enable & ~mem_wr};
    pipe_d[0] <= mem_set[mem_addr[15:1]] ? mem_arr[mem_addr[15:1]] : mem_addr;
    pipe_d[1] <= pipe_d[0];
    pipe_d[2] <= pipe_d[1];
    pipe_d[3] <= pipe_d[2];
  end

  assign mem_data_valid = pipe_v[3] | stray_v;
  assign mem_data_out   = stray_v ? stray_d : pipe_d[3];

  // ---------------- scoreboard ----------------
  logic [15:0] q_rd [$];
  logic [31:0] q_cw [$];
  logic [15:0] q_tag [$];
  logic [31:0] q_wr [$];
  logic [15:0] over [logic [15:0]];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected event %h, expected none", name, act);
  endtask

  function automatic logic [95:0] outs();
    return {10'b0, cpu_wr_ack, fsm_busy, mem_enable, mem_wr, write_data_array,
            write_tag_array, mem_addr, mem_data_in, cache_word_addr, cache_data, tag_addr};
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return over.exists(a) ? over[a] : a;
  endfunction

  // Monitor: pops the expected transaction whenever the DUT produces one.
  initial begin
    logic [15:0] e16;
    logic [31:0] e32;
    forever begin
      @(negedge clk);
      if (mem_enable && !mem_wr) begin
        if (q_rd.size() == 0) unexpected("mem_read", {16'h0000, mem_addr});
        else begin e16 = q_rd.pop_front(); chk("mem_read_addr", {80'b0, mem_addr}, {80'b0, e16}); end
      end
      if (mem_enable && mem_wr) begin
        if (q_wr.size() == 0) unexpected("mem_store", {mem_addr, mem_data_in});
        else begin e32 = q_wr.pop_front(); chk("mem_store", {64'b0, mem_addr, mem_data_in}, {64'b0, e32}); end
      end
      if (write_data_array) begin
        if (q_cw.size() == 0) unexpected("cache_write", {cache_word_addr, cache_data});
        else begin e32 = q_cw.pop_front(); chk("cache_write", {64'b0, cache_word_addr, cache_data}, {64'b0, e32}); end
      end
      if (write_tag_array) begin
        if (q_tag.size() == 0) unexpected("tag_write", {16'h0000, tag_addr});
        else begin e16 = q_tag.pop_front(); chk("tag_write", {80'b0, tag_addr}, {80'b0, e16}); end
      end
    end
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- IDLE vector table ----------------
  typedef struct {
    logic        wr_req;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        sv;
    logic [15:0] sd;
    logic        ack;
    logic        en;
    logic        wr;
    logic [15:0] maddr;
    logic [15:0] mdin;
  } vec_t;

  vec_t tbl [6];

  // Full miss: expectations queued in cycle 0, timing checked every cycle.
  task automatic run_fill(input logic [15:0] ma, input logic hold_store,
                          input logic [15:0] sa, input logic [15:0] sd);
    logic [15:0] base;
    logic [15:0] a;
    base = {ma[15:4], 4'h0};
    next_cycle();
    miss_detected = 1'b1;
    miss_address  = ma;
    cpu_wr_req    = hold_store;
    cpu_wr_addr   = sa;
    cpu_wr_data   = sd;
    for (int w = 0; w < 8; w++) begin
      a = base + 16'(2 * w);
      q_rd.push_back(a);
      q_cw.push_back({a, exp_word(a)});
    end
    q_tag.push_back(base);
    @(negedge clk);
    chk($sformatf("fill_%h_c0", ma), {93'b0, fsm_busy, cpu_wr_ack, mem_enable}, 96'b0);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      if (c == 3) miss_address = ~ma;
      if (c == 13) begin
        miss_detected = 1'b0;
        if (hold_store) begin
          q_wr.push_back({sa, sd});
          over[sa] = sd;
        end
      end
      @(negedge clk);
      chk($sformatf("fill_%h_c%0d", ma, c),
          {91'b0, fsm_busy, mem_enable && !mem_wr, write_data_array, write_tag_array, cpu_wr_ack},
          {91'b0, 1'(c <= 12), 1'(c <= 8), 1'(c >= 5 && c <= 12), 1'(c == 12), 1'(hold_store && c == 13)});
    end
    next_cycle();
    cpu_wr_req = 1'b0;
    @(negedge clk);
    chk($sformatf("fill_%h_drain", ma),
        {32'b0, 16'(q_rd.size()), 16'(q_cw.size()), 16'(q_tag.size()), 16'(q_wr.size())}, 96'b0);
  endtask

  initial begin
    rst           = 1'b1;
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    cpu_wr_req    = 1'b1;
    cpu_wr_addr   = 16'h0040;
    cpu_wr_data   = 16'h1111;

    tbl[0] = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF};
    tbl[2] = '{1'b0, 16'h3333, 16'h4444, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 16'h0FFE, 16'h1234, 1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b1, 16'h0FFE, 16'h1234};
    tbl[4] = '{1'b1, 16'h7FFC, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h7FFC, 16'hA5A5};
    tbl[5] = '{1'b0, 16'h5678, 16'h9ABC, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    // Reset state: every output low even with miss and store requested.
    @(negedge clk);
    chk("reset_outputs", outs(), 96'b0);
    next_cycle();
    rst           = 1'b0;
    miss_detected = 1'b0;
    cpu_wr_req    = 1'b0;

    // IDLE: store forwarding and stray read returns.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      cpu_wr_req  = tbl[i].wr_req;
      cpu_wr_addr = tbl[i].wa;
      cpu_wr_data = tbl[i].wd;
      stray_v     = tbl[i].sv;
      stray_d     = tbl[i].sd;
      if (tbl[i].ack) begin
        q_wr.push_back({tbl[i].wa, tbl[i].wd});
        over[tbl[i].wa] = tbl[i].wd;
      end
      @(negedge clk);
      chk($sformatf("idle_vec%0d", i), outs(),
          {10'b0, tbl[i].ack, 1'b0, tbl[i].en, tbl[i].wr, 1'b0, 1'b0,
           tbl[i].maddr, tbl[i].mdin, 16'h0000, 16'h0000, 16'h0000});
    end
    next_cycle();
    cpu_wr_req = 1'b0;
    stray_v    = 1'b0;

    // Basic fill, then miss+store collision (block holds the 0xBEEF store),
    // then a fill at the top of the address space.
    run_fill(16'h1236, 1'b0, 16'h0000, 16'h0000);
    run_fill(16'h0040, 1'b1, 16'h0100, 16'h7777);
    run_fill(16'hFFFE, 1'b0, 16'h0000, 16'h0000);

    // Reset mid-fill at 0x2000: asserted in cycle 6, released in cycle 7.
    next_cycle();
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    for (int w = 0; w < 8; w++) begin
      q_rd.push_back(16'h2000 + 16'(2 * w));
      q_cw.push_back({16'h2000 + 16'(2 * w), exp_word(16'h2000 + 16'(2 * w))});
    end
    q_tag.push_back(16'h2000);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    rst         = 1'b1;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 16'h0300;
    cpu_wr_data = 16'h3030;
    q_rd.delete();
    q_cw.delete();
    q_tag.delete();
    #1;
    chk("rst_midfill_outputs", outs(), 96'b0);
    next_cycle();
    rst           = 1'b0;
    miss_detected = 1'b0;
    cpu_wr_req    = 1'b0;
    for (int c = 7; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_c%0d", c), {93'b0, fsm_busy, write_data_array, write_tag_array}, 96'b0);
      if (c < 13) next_cycle();
    end
    chk("final_drain",
        {32'b0, 16'(q_rd.size()), 16'(q_cw.size()), 16'(q_tag.size()), 16'(q_wr.size())}, 96'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Read-initiator and write-forwarder that sits between the cache arrays and the multi-cycle main memory. On a cache miss it fetches a whole block by issuing one pipelined word read per cycle, counts the words returned under `data_valid`, and writes each one into the cache data array, then writes the tag. When no fill is active it forwards single-word write-through stores to memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte-address width. Must match the memory.
- `BLOCK_WORDS`, default 8: 16-bit words per cache block. Must be a power of two, ≥2.
- Derived `OFS` = log2(`BLOCK_WORDS`)+1: byte-offset bits within a block.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `miss_detected`  in  1  cache miss request; level, held by the cache until the fill completes.
- `miss_address`  in  ADDR_WIDTH  byte address that missed.
- `cpu_wr_req`  in  1  write-through store request.
- `cpu_wr_addr`  in  ADDR_WIDTH  store byte address; bit 0 is 0.
- `cpu_wr_data`  in  16  store data.
- `cpu_wr_ack`  out  1  store forwarded to memory this cycle.
- `fsm_busy`  out  1  fill in progress.
- `mem_enable`  out  1  memory enable.
- `mem_wr`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  memory byte address.
- `mem_data_in`  out  16  memory write data.
- `mem_data_out`  in  16  memory read data.
- `mem_data_valid`  in  1  read data valid; arrives 4 cycles after the enable cycle.
- `write_data_array`  out  1  cache data-array write strobe.
- `cache_word_addr`  out  ADDR_WIDTH  byte address of the word being written into the cache.
- `cache_data`  out  16  word written into the cache (equals `mem_data_out`).
- `write_tag_array`  out  1  cache tag-array write strobe.
- `tag_addr`  out  ADDR_WIDTH  block base address for the tag write.

## Operation
- **States:** IDLE and FILL.
- **Registers:** `base` (ADDR_WIDTH), `issue_cnt` (OFS bits), `ret_cnt` (OFS bits).
- **IDLE:**
  - If `miss_detected`=1: latch `base` = `{miss_address[ADDR_WIDTH-1:OFS], OFS'b0}`, clear both counters, go to FILL.
  - Otherwise, if `cpu_wr_req`=1: `cpu_wr_ack`=1, `mem_enable`=1, `mem_wr`=1, `mem_addr`=`cpu_wr_addr`, `mem_data_in`=`cpu_wr_data` (combinational, same cycle).
  - A miss has priority over a store in the same cycle; the store is not acknowledged.
- **FILL, issue side:**
  - While `issue_cnt` < `BLOCK_WORDS`: `mem_enable`=1, `mem_wr`=0, `mem_addr` = `base` + 2·`issue_cnt`; `issue_cnt` increments each cycle.
  - After the last issue: `mem_enable`=0.
- **FILL, return side:**
  - Each cycle with `mem_data_valid`=1: `write_data_array`=1, `cache_word_addr` = `base` + 2·`ret_cnt`, `cache_data`=`mem_data_out`; `ret_cnt` increments.
- **Fill completion:** when `ret_cnt`=`BLOCK_WORDS`-1 and `mem_data_valid`=1:
  - assert `write_tag_array`=1 with `tag_addr`=`base` in that same cycle;
  - go to IDLE at the next edge.
- **Stray or unexpected inputs:**
  - `mem_data_valid` in IDLE is ignored: no cache writes.
  - `cpu_wr_req` during FILL: `cpu_wr_ack`=0; the store stalls.
  - `miss_detected` changes during FILL are ignored.
- **Address arithmetic:** modulo 2^ADDR_WIDTH. The low OFS bits of `base` are always zero, so block addresses never carry into the tag bits.
- **Combinational outputs:** `fsm_busy` = (state==FILL). Unused outputs drive 0; `tag_addr`=`base` at all times.

## Timing
- **Reset:** asserting `rst` (asynchronous) forces state IDLE and `base`, `issue_cnt`, `ret_cnt` = 0.
  - While `rst`=1, all outputs are 0, including `cpu_wr_ack` and `mem_enable`.
- **Fill schedule:** miss accepted at edge E0 (cycle 0 is IDLE with `miss_detected`=1).
  - Issues occur in cycles 1..`BLOCK_WORDS`.
  - Returns occur in cycles 5..`BLOCK_WORDS`+4.
  - The tag write coincides with the last data write (cycle 12 for 8 words).
  - `fsm_busy` is high in cycles 1..12 and low in cycle 13.
- **Back-to-back misses:** earliest new acceptance is in cycle 13 (the first IDLE cycle); the next fill begins issuing in cycle 14.
- **Reset mid-fill:** the fill is abandoned. Data still in the memory pipeline that arrives after reset deasserts is ignored (IDLE). There is no tag write.
- **Write path:** a store costs exactly one cycle; there is no outstanding state.

## Test plan
- **Basic fill:** miss at 0x1236, `BLOCK_WORDS`=8, memory preloaded with word = address.
  - Reads at 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - `write_data_array` in cycles 5–12 with `cache_data` 0x1230…0x123E.
  - `write_tag_array` in cycle 12 with `tag_addr`=0x1230; `fsm_busy` falls in cycle 13.
- **Store forwarding:** in IDLE, `cpu_wr_req` to 0x0040 with data 0xBEEF.
  - Same cycle: `cpu_wr_ack`=1, `mem_wr`=1, `mem_addr`=0x0040.
  - A later miss at 0x0040 fills 0xBEEF into word 0.
- **Simultaneous miss and store:** both in the same IDLE cycle.
  - `cpu_wr_ack`=0, fill starts.
  - A store held through the fill gets `cpu_wr_ack` in cycle 13.
- **Reset mid-fill:** assert `rst` in cycle 6 of a fill at 0x2000, release in cycle 7.
  - Outputs are 0 immediately on assertion.
  - No `write_data_array` or `write_tag_array` occurs afterwards despite late `mem_data_valid`.
- **Wrap-around:** miss at 0xFFFE.
  - `base`=0xFFF0; reads at 0xFFF0..0xFFFE.
  - `tag_addr`=0xFFF0; no address overflow.
- **Stray valid:** `mem_data_valid` pulsed in IDLE produces no cache write.
